sub_serial: RTL and testbench

Bit-serial 8-bit subtractor: the inverse arithmetic companion to the serial adder in the obfuscated-control datapath family. It unscrambles two masked operands, computes (a − b) mod 256 one bit per clock, LSB first, and reports the final borrow. The control FSM carries key-gated decoy states, matching the control-obfuscation style of the serial arithmetic blocks. A wrong key walks the FSM through a decoy chain without touching the datapath.

---
 rtl/serial_arith_pkg.sv | 23 ++
 rtl/full_sub_bit.sv | 13 +
 rtl/sub_serial.sv | 113 +++++++++++
 tb/tb_sub_serial.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial arithmetic blocks.
// State encoding, operand width and default mask/key values.
package serial_arith_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] DEF_A_MASK = 8'hC1;
    localparam logic [WIDTH-1:0] DEF_B_MASK = 8'hC7;
    localparam logic [WIDTH-1:0] DEF_KEY    = 8'hA5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SUB  = 3'd1,
        DONE = 3'd2,
        DLY0 = 3'd3,
        DLY1 = 3'd4,
        DLY2 = 3'd5,
        DLY3 = 3'd6,
        DLY4 = 3'd7
    } state_t;

endpackage

// File: rtl/full_sub_bit.sv
// Combinational 1-bit full subtractor: d = a - b - bin.
module full_sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial masked 8-bit subtractor, LSB first, with a key-gated
// control FSM that runs a decoy chain on a wrong key.
module sub_serial
    import serial_arith_pkg::*;
#(
    parameter logic [WIDTH-1:0] A_MASK = DEF_A_MASK,
    parameter logic [WIDTH-1:0] B_MASK = DEF_B_MASK,
    parameter logic [WIDTH-1:0] KEY    = DEF_KEY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] key,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             borrow_out,
    output logic             done,
    output logic             busy
);

    state_t             state;
    state_t             state_n;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [CNT_W-1:0]   count;
    logic               borrow;
    logic               load;
    logic               shift;
    logic               last;
    logic               d_bit;
    logic               b_next;

    full_sub_bit u_bit (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .bin  (borrow),
        .d    (d_bit),
        .bout (b_next)
    );

    assign last = (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (en) begin
                    if (key == KEY) begin
                        load    = 1'b1;
                        state_n = SUB;
                    end else begin
                        state_n = DLY0;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            SUB: begin
                shift = 1'b1;
                if (last) begin
                    state_n = DONE;
                end
            end
            DLY0: state_n = DLY1;
            DLY1: state_n = DLY2;
            DLY2: state_n = DLY3;
            DLY3: state_n = DLY4;
            DLY4: state_n = IDLE;
        endcase
    end

    // Decoy states fall through both branches, so the datapath holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            out        <= '0;
            count      <= '0;
            borrow     <= 1'b0;
            borrow_out <= 1'b0;
        end else if (load) begin
            a_reg  <= a ^ A_MASK;
            b_reg  <= b ^ B_MASK;
            out    <= '0;
            count  <= '0;
            borrow <= 1'b0;
        end else if (shift) begin
            a_reg  <= a_reg >> 1;
            b_reg  <= b_reg >> 1;
            out    <= {d_bit, out[WIDTH-1:1]};
            count  <= count + 1'b1;
            borrow <= b_next;
            if (last) begin
                borrow_out <= b_next;
            end
        end
    end

    assign done = (state == DONE);
    assign busy = (state == SUB) || (state >= DLY0);

endmodule

// File: tb/tb_sub_serial.sv
// Directed bench for sub_serial with an expected-result queue
// filled at each valid start and drained when done rises.
module tb_sub_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] key = 8'h00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [7:0] out;
    logic       borrow_out;
    logic       done;
    logic       busy;

    int passed = 0;
    int failed = 0;
    int total = 0;

    logic [8:0] sb[$];

    sub_serial dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .key        (key),
        .a          (a),
        .b          (b),
        .out        (out),
        .borrow_out (borrow_out),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] ma,
                                         input logic [7:0] mb);
        logic [7:0] ua;
        logic [7:0] ub;
        ua = ma ^ 8'hC1;
        ub = mb ^ 8'hC7;
        return {ua < ub, 8'(ua - ub)};
    endfunction

    // Called at a negedge; returns at the next negedge with en low.
    task automatic start(input logic [7:0] ma, input logic [7:0] mb,
                         input logic [7:0] k, input bit push);
        a = ma;
        b = mb;
        key = k;
        en = 1'b1;
        if (push) sb.push_back(model(ma, mb));
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int n);
        logic [8:0] e;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        if (done && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_out"}, 32'(out), 32'(e[7:0]));
            check({tag, "_borrow"}, 32'(borrow_out), 32'(e[8]));
        end
    endtask

    initial begin
        int n;
        int bcnt;
        int dseen;

        repeat (2) @(negedge clk);
        check("rst_out", 32'(out), 32'h0);
        check("rst_borrow", 32'(borrow_out), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        start(8'hC2, 8'hC2, 8'hA5, 1'b1);
        check("sub35_busy", 32'(busy), 32'h1);
        wait_done("sub35", n);
        check("sub35_latency", 32'(n), 32'd8);
        @(negedge clk);

        start(8'hC4, 8'hC4, 8'hA5, 1'b1);
        wait_done("sub53", n);
        check("sub53_latency", 32'(n), 32'd8);
        @(negedge clk);
        check("idle_done", 32'(done), 32'h0);

        start(8'hC4, 8'hC4, 8'h00, 1'b0);
        bcnt = 0;
        dseen = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) bcnt++;
            if (done) dseen++;
            @(negedge clk);
        end
        check("decoy_busy_cycles", 32'(bcnt), 32'd5);
        check("decoy_done", 32'(dseen), 32'd0);
        check("decoy_out", 32'(out), 32'h02);
        check("decoy_borrow", 32'(borrow_out), 32'h0);
        check("decoy_idle_busy", 32'(busy), 32'h0);

        a = 8'hC1;
        b = 8'hC7;
        key = 8'hA5;
        en = 1'b1;
        sb.push_back(model(8'hC1, 8'hC7));
        sb.push_back(model(8'hC1, 8'hC7));
        @(negedge clk);
        wait_done("b2b_first", n);
        @(negedge clk);
        check("b2b_gap_done", 32'(done), 32'h0);
        check("b2b_gap_busy", 32'(busy), 32'h1);
        wait_done("b2b_second", n);
        check("b2b_latency", 32'(n), 32'd8);
        en = 1'b0;
        @(negedge clk);

        start(8'hC4, 8'hC4, 8'hA5, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        void'(sb.pop_front());
        check("arst_out", 32'(out), 32'h0);
        check("arst_count", 32'(dut.count), 32'h0);
        check("arst_borrow", 32'(dut.borrow), 32'h0);
        check("arst_borrow_out", 32'(borrow_out), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start(8'hC4, 8'hC4, 8'hA5, 1'b1);
        wait_done("post_rst", n);
        check("post_rst_latency", 32'(n), 32'd8);
        @(negedge clk);

        start(8'hC4, 8'hC4, 8'hA5, 1'b1);
        for (int i = 0; i < 40 && !done; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            key = 8'($urandom);
            @(negedge clk);
        end
        wait_done("scramble", n);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
